cgra_tcdm_xbar: RTL and testbench

//  Parametrised column-to-TCDM-port crossbar. Successor to the fixed 4-col/MP-port data path under the CGRA top.

---
 rtl/cgra_pkg.sv | 19 +
 rtl/cgra_id_fifo.sv | 71 +++++++
 rtl/cgra_tcdm_xbar.sv | 202 ++++++++++++++++++++
 tb/tb_cgra_tcdm_xbar.sv | 338 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cgra_pkg.sv
// Shared types and constants for the CGRA column-to-TCDM crossbar.
// Mode encodings and the request payload bundle.
package cgra_pkg;

  localparam logic XBAR_MODE_FIXED = 1'b0;
  localparam logic XBAR_MODE_IL    = 1'b1;

  localparam int unsigned XBAR_ADDR_W = 32;
  localparam int unsigned XBAR_DATA_W = 32;
  localparam int unsigned XBAR_BE_W   = 4;

  typedef struct packed {
    logic                   we;
    logic [XBAR_BE_W-1:0]   be;
    logic [XBAR_ADDR_W-1:0] addr;
    logic [XBAR_DATA_W-1:0] wdata;
  } xbar_req_t;

endpackage

// File: rtl/cgra_id_fifo.sv
// Requester-ID FIFO, one per bus port; records grant order so responses
// return to the right column. Ports: push/data_i in, pop/data_o head, full/empty/cnt.
module cgra_id_fifo #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned W     = 2
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         push_i,
  input  logic [W-1:0]                 data_i,
  input  logic                         pop_i,
  output logic [W-1:0]                 data_o,
  output logic                         full_o,
  output logic                         empty_o,
  output logic [$clog2(DEPTH+1)-1:0]   cnt_o
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW    = $clog2(DEPTH + 1);

  logic [DEPTH-1:0][W-1:0] mem_q, mem_d;
  logic [PTR_W-1:0]        wr_q, wr_d;
  logic [PTR_W-1:0]        rd_q, rd_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic                    do_push, do_pop;

  function automatic logic [PTR_W-1:0] nxt(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  always_comb begin
    mem_d   = mem_q;
    wr_d    = wr_q;
    rd_d    = rd_q;
    cnt_d   = cnt_q;
    do_pop  = pop_i && (cnt_q != '0);
    do_push = push_i && ((cnt_q != CW'(DEPTH)) || do_pop);
    if (do_push) begin
      mem_d[wr_q] = data_i;
      wr_d        = nxt(wr_q);
    end
    if (do_pop) begin
      rd_d = nxt(rd_q);
    end
    if (do_push && !do_pop) begin
      cnt_d = cnt_q + CW'(1);
    end else if (!do_push && do_pop) begin
      cnt_d = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mem_q <= '0;
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  assign data_o  = mem_q[rd_q];
  assign full_o  = (cnt_q == CW'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign cnt_o   = cnt_q;

endmodule

// File: rtl/cgra_tcdm_xbar.sv
// Column-to-TCDM-port crossbar: N_REQ requesters onto N_PORT bus ports,
// fixed or interleaved routing, per-port RR with lock, in-order responses.
module cgra_tcdm_xbar
  import cgra_pkg::*;
#(
  parameter int unsigned N_REQ     = 4,
  parameter int unsigned N_PORT    = 4,
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned MAX_OUTST = 2,
  parameter int unsigned IL_LSB    = 2
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic                           mode_i,
  input  logic [N_REQ-1:0]               req_req_i,
  input  logic [N_REQ-1:0]               req_we_i,
  input  logic [N_REQ-1:0][3:0]          req_be_i,
  input  logic [N_REQ-1:0][ADDR_W-1:0]   req_addr_i,
  input  logic [N_REQ-1:0][DATA_W-1:0]   req_wdata_i,
  output logic [N_REQ-1:0]               req_gnt_o,
  output logic [N_REQ-1:0]               req_rvalid_o,
  output logic [N_REQ-1:0][DATA_W-1:0]   req_rdata_o,
  output logic [N_REQ-1:0]               stall_o,
  output logic [N_PORT-1:0]              bus_req_o,
  output logic [N_PORT-1:0]              bus_we_o,
  output logic [N_PORT-1:0][3:0]         bus_be_o,
  output logic [N_PORT-1:0][ADDR_W-1:0]  bus_addr_o,
  output logic [N_PORT-1:0][DATA_W-1:0]  bus_wdata_o,
  input  logic [N_PORT-1:0]              bus_gnt_i,
  input  logic [N_PORT-1:0]              bus_rvalid_i,
  input  logic [N_PORT-1:0][DATA_W-1:0]  bus_rdata_i,
  output logic                           busy_o,
  output logic                           err_o
);

  localparam int unsigned IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int unsigned PW = (N_PORT > 1) ? $clog2(N_PORT) : 1;
  localparam int unsigned CW = $clog2(MAX_OUTST + 1);
  localparam int unsigned FW = $clog2(MAX_OUTST + 1);
  localparam logic [PW-1:0] PMASK = PW'(N_PORT - 1);

  logic                      mode_q, mode_d;
  logic                      err_q, err_d;
  logic [N_PORT-1:0][IW-1:0] rr_q, rr_d;
  logic [N_PORT-1:0][IW-1:0] lock_q, lock_d;
  logic [N_PORT-1:0]         lock_vld_q, lock_vld_d;
  logic [N_REQ-1:0][CW-1:0]  ocnt_q, ocnt_d;
  logic [N_REQ-1:0][PW-1:0]  lport_q, lport_d;

  logic [N_REQ-1:0][PW-1:0]  tgt;
  logic [N_REQ-1:0]          elig, inc, dec;
  logic [N_PORT-1:0][IW-1:0] sel, head;
  logic [N_PORT-1:0]         push, pop, f_full, f_empty;
  logic [N_PORT-1:0][FW-1:0] fifo_cnt;

  // A requester with responses pending may only issue to the same port,
  // otherwise two ports could answer it out of order.
  always_comb begin
    tgt  = '0;
    elig = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (mode_q == XBAR_MODE_IL) begin
        tgt[i] = req_addr_i[i][IL_LSB +: PW] & PMASK;
      end else begin
        tgt[i] = PW'(i % N_PORT);
      end
      elig[i] = req_req_i[i] &&
                ((ocnt_q[i] == '0) || (tgt[i] == lport_q[i]));
    end
  end

  always_comb begin
    logic             hit;
    logic [IW-1:0]    ci;
    bus_req_o    = '0;
    bus_we_o     = '0;
    bus_be_o     = '0;
    bus_addr_o   = '0;
    bus_wdata_o  = '0;
    req_gnt_o    = '0;
    req_rvalid_o = '0;
    req_rdata_o  = '0;
    sel          = '0;
    push         = '0;
    pop          = '0;
    inc          = '0;
    dec          = '0;
    rr_d         = rr_q;
    lock_d       = lock_q;
    lock_vld_d   = '0;
    lport_d      = lport_q;
    err_d        = err_q;
    for (int p = 0; p < N_PORT; p++) begin
      hit = 1'b0;
      ci  = '0;
      // Hold a raised request on the same requester until granted.
      if (lock_vld_q[p] && elig[lock_q[p]] &&
          (tgt[lock_q[p]] == PW'(p))) begin
        hit    = 1'b1;
        sel[p] = lock_q[p];
      end
      for (int j = 0; j < N_REQ; j++) begin
        ci = IW'((32'(rr_q[p]) + 32'(j)) % N_REQ);
        if (!hit && elig[ci] && (tgt[ci] == PW'(p))) begin
          hit    = 1'b1;
          sel[p] = ci;
        end
      end
      // Registered full flag only: no rvalid->req combinational path.
      bus_req_o[p] = hit && !f_full[p];
      if (bus_req_o[p]) begin
        bus_we_o[p]    = req_we_i[sel[p]];
        bus_be_o[p]    = req_be_i[sel[p]];
        bus_addr_o[p]  = req_addr_i[sel[p]];
        bus_wdata_o[p] = req_wdata_i[sel[p]];
      end
      push[p] = bus_req_o[p] && bus_gnt_i[p];
      if (push[p]) begin
        req_gnt_o[sel[p]] = 1'b1;
        inc[sel[p]]       = 1'b1;
        lport_d[sel[p]]   = PW'(p);
        rr_d[p]           = IW'((32'(sel[p]) + 32'd1) % N_REQ);
      end else if (bus_req_o[p]) begin
        lock_vld_d[p] = 1'b1;
        lock_d[p]     = sel[p];
      end
      pop[p] = bus_rvalid_i[p] && !f_empty[p];
      if (pop[p]) begin
        req_rvalid_o[head[p]] = 1'b1;
        req_rdata_o[head[p]]  = bus_rdata_i[p];
        dec[head[p]]          = 1'b1;
      end
      if (bus_rvalid_i[p] && f_empty[p]) begin
        err_d = 1'b1;
      end
    end
  end

  always_comb begin
    ocnt_d = ocnt_q;
    for (int i = 0; i < N_REQ; i++) begin
      if (inc[i] && !dec[i]) begin
        ocnt_d[i] = ocnt_q[i] + CW'(1);
      end else if (!inc[i] && dec[i]) begin
        ocnt_d[i] = ocnt_q[i] - CW'(1);
      end
    end
  end

  // Mode may only change while the crossbar is fully idle.
  always_comb begin
    busy_o = 1'b0;
    for (int p = 0; p < N_PORT; p++) begin
      if (fifo_cnt[p] != '0) begin
        busy_o = 1'b1;
      end
    end
    mode_d = (!busy_o && (bus_req_o == '0)) ? mode_i : mode_q;
  end

  for (genvar p = 0; p < N_PORT; p++) begin : g_fifo
    cgra_id_fifo #(
      .DEPTH (MAX_OUTST),
      .W     (IW)
    ) u_fifo (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .push_i  (push[p]),
      .data_i  (sel[p]),
      .pop_i   (pop[p]),
      .data_o  (head[p]),
      .full_o  (f_full[p]),
      .empty_o (f_empty[p]),
      .cnt_o   (fifo_cnt[p])
    );
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mode_q     <= XBAR_MODE_FIXED;
      err_q      <= 1'b0;
      rr_q       <= '0;
      lock_q     <= '0;
      lock_vld_q <= '0;
      ocnt_q     <= '0;
      lport_q    <= '0;
    end else begin
      mode_q     <= mode_d;
      err_q      <= err_d;
      rr_q       <= rr_d;
      lock_q     <= lock_d;
      lock_vld_q <= lock_vld_d;
      ocnt_q     <= ocnt_d;
      lport_q    <= lport_d;
    end
  end

  assign stall_o = req_req_i & ~req_gnt_o;
  assign err_o   = err_q;

endmodule

// File: tb/tb_cgra_tcdm_xbar.sv
// Directed bench for cgra_tcdm_xbar with a per-port response scoreboard.
// Bench drives the bus side as a simple slave.
module tb_cgra_tcdm_xbar;

  localparam int NR = 4;
  localparam int NP = 4;
  localparam int AW = 32;
  localparam int DW = 32;

  logic                  clk = 1'b0;
  logic                  rst_i;
  logic                  mode_i;
  logic [NR-1:0]         req_req_i;
  logic [NR-1:0]         req_we_i;
  logic [NR-1:0][3:0]    req_be_i;
  logic [NR-1:0][AW-1:0] req_addr_i;
  logic [NR-1:0][DW-1:0] req_wdata_i;
  logic [NR-1:0]         req_gnt_o;
  logic [NR-1:0]         req_rvalid_o;
  logic [NR-1:0][DW-1:0] req_rdata_o;
  logic [NR-1:0]         stall_o;
  logic [NP-1:0]         bus_req_o;
  logic [NP-1:0]         bus_we_o;
  logic [NP-1:0][3:0]    bus_be_o;
  logic [NP-1:0][AW-1:0] bus_addr_o;
  logic [NP-1:0][DW-1:0] bus_wdata_o;
  logic [NP-1:0]         bus_gnt_i;
  logic [NP-1:0]         bus_rvalid_i;
  logic [NP-1:0][DW-1:0] bus_rdata_i;
  logic                  busy_o;
  logic                  err_o;

  always #5 clk = ~clk;

  cgra_tcdm_xbar #(
    .N_REQ(NR), .N_PORT(NP), .ADDR_W(AW), .DATA_W(DW),
    .MAX_OUTST(2), .IL_LSB(2)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst_i),
    .mode_i       (mode_i),
    .req_req_i    (req_req_i),
    .req_we_i     (req_we_i),
    .req_be_i     (req_be_i),
    .req_addr_i   (req_addr_i),
    .req_wdata_i  (req_wdata_i),
    .req_gnt_o    (req_gnt_o),
    .req_rvalid_o (req_rvalid_o),
    .req_rdata_o  (req_rdata_o),
    .stall_o      (stall_o),
    .bus_req_o    (bus_req_o),
    .bus_we_o     (bus_we_o),
    .bus_be_o     (bus_be_o),
    .bus_addr_o   (bus_addr_o),
    .bus_wdata_o  (bus_wdata_o),
    .bus_gnt_i    (bus_gnt_i),
    .bus_rvalid_i (bus_rvalid_i),
    .bus_rdata_i  (bus_rdata_i),
    .busy_o       (busy_o),
    .err_o        (err_o)
  );

  typedef struct {
    int unsigned idx;
    logic [31:0] data;
  } sb_t;

  sb_t         sbq [NP][$];
  int          errors = 0;
  int          checks = 0;
  logic [31:0] dnext  = 32'hD000_0000;

  task automatic chk(input string tag, input logic [127:0] obs,
                     input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    bus_gnt_i    = '0;
    bus_rvalid_i = '0;
    bus_rdata_i  = '0;
  endtask

  task automatic exp_push(input int p, input int unsigned idx);
    sb_t e;
    e.idx  = idx;
    e.data = dnext;
    dnext  = dnext + 32'h11;
    sbq[p].push_back(e);
  endtask

  // Drive rvalid on the masked ports with scoreboard data, then check
  // which requesters see it and with what data.
  task automatic rsp(input logic [NP-1:0] m, input string tag);
    logic [NR-1:0]         ev;
    logic [NR-1:0][DW-1:0] ed;
    sb_t                   e;
    ev = '0;
    ed = '0;
    bus_rvalid_i = m;
    for (int p = 0; p < NP; p++) begin
      if (m[p]) begin
        chk({tag, "_sbsize"}, 128'(sbq[p].size() != 0), 128'(1));
        if (sbq[p].size() != 0) begin
          e = sbq[p].pop_front();
          bus_rdata_i[p] = e.data;
          ev[e.idx]      = 1'b1;
          ed[e.idx]      = e.data;
        end
      end
    end
    #3;
    chk({tag, "_rvalid"}, 128'(req_rvalid_o), 128'(ev));
    chk({tag, "_rdata"}, 128'(req_rdata_o), 128'(ed));
  endtask

  initial begin
    rst_i        = 1'b1;
    mode_i       = 1'b0;
    req_req_i    = '0;
    req_we_i     = '0;
    req_be_i     = '0;
    req_addr_i   = '0;
    req_wdata_i  = '0;
    bus_gnt_i    = '0;
    bus_rvalid_i = '0;
    bus_rdata_i  = '0;
    tick();
    tick();
    rst_i = 1'b0;
    #3;
    chk("rst_bus_req", 128'(bus_req_o), 128'(0));
    chk("rst_gnt", 128'(req_gnt_o), 128'(0));
    chk("rst_busy", 128'(busy_o), 128'(0));
    chk("rst_err", 128'(err_o), 128'(0));
    chk("rst_rvalid", 128'(req_rvalid_o), 128'(0));

    // Fixed mode, all four columns read their own port.
    tick();
    req_req_i = 4'hF;
    req_be_i  = {4'hF, 4'h3, 4'hC, 4'h1};
    for (int i = 0; i < NR; i++) req_addr_i[i] = 32'h100 * i + 32'h40;
    bus_gnt_i = 4'hF;
    #3;
    chk("t1_bus_req", 128'(bus_req_o), 128'hF);
    chk("t1_gnt", 128'(req_gnt_o), 128'hF);
    chk("t1_stall", 128'(stall_o), 128'h0);
    chk("t1_addr", 128'(bus_addr_o),
        {32'h340, 32'h240, 32'h140, 32'h040});
    chk("t1_be", 128'(bus_be_o), 128'(16'hF3C1));
    for (int i = 0; i < NP; i++) exp_push(i, i);
    tick();
    req_req_i = '0;
    rsp(4'hF, "t1_rsp");
    chk("t1_busy", 128'(busy_o), 128'(1));
    tick();
    #3;
    chk("t1_idle", 128'(busy_o), 128'(0));

    // Interleaved: req0 and req2 both map to port 0.
    tick();
    rst_i = 1'b1;
    tick();
    rst_i  = 1'b0;
    mode_i = 1'b1;
    tick();
    req_req_i     = 4'b0101;
    req_addr_i[0] = 32'h0;
    req_addr_i[2] = 32'h10;
    bus_gnt_i     = 4'b0001;
    #3;
    chk("t2_gnt0", 128'(req_gnt_o), 128'b0001);
    chk("t2_stall", 128'(stall_o), 128'b0100);
    chk("t2_addr0", 128'(bus_addr_o[0]), 128'h0);
    exp_push(0, 0);
    tick();
    req_req_i = 4'b0100;
    bus_gnt_i = 4'b0001;
    rsp(4'b0001, "t2_rsp0");
    chk("t2_gnt2", 128'(req_gnt_o), 128'b0100);
    chk("t2_addr2", 128'(bus_addr_o[0]), 128'h10);
    exp_push(0, 2);
    tick();
    req_req_i = '0;
    rsp(4'b0001, "t2_rsp2");
    tick();
    req_req_i = 4'b0101;
    bus_gnt_i = 4'b0001;
    #3;
    chk("t2_rr3", 128'(req_gnt_o), 128'b0001);
    exp_push(0, 0);
    tick();
    req_req_i = '0;
    rsp(4'b0001, "t2_rsp3");

    // Port 1 withholds grant while req1 and req3 contend.
    tick();
    req_req_i     = 4'b1010;
    req_addr_i[1] = 32'h4;
    req_addr_i[3] = 32'h14;
    for (int c = 0; c < 5; c++) begin
      #3;
      chk("t3_hold_req", 128'(bus_req_o), 128'b0010);
      chk("t3_hold_addr", 128'(bus_addr_o[1]), 128'h4);
      chk("t3_hold_stall", 128'(stall_o), 128'b1010);
      tick();
    end
    bus_gnt_i = 4'b0010;
    #3;
    chk("t3_gnt1", 128'(req_gnt_o), 128'b0010);
    exp_push(1, 1);
    tick();
    req_req_i = 4'b1000;
    bus_gnt_i = 4'b0010;
    rsp(4'b0010, "t3_rsp1");
    chk("t3_gnt3", 128'(req_gnt_o), 128'b1000);
    chk("t3_addr3", 128'(bus_addr_o[1]), 128'h14);
    exp_push(1, 3);
    tick();
    req_req_i = '0;
    rsp(4'b0010, "t3_rsp3");

    // Outstanding limit of 2 on port 2.
    tick();
    req_req_i     = 4'b0001;
    req_addr_i[0] = 32'h8;
    bus_gnt_i     = 4'b0100;
    #3;
    chk("t4_gnt_a", 128'(req_gnt_o), 128'b0001);
    exp_push(2, 0);
    tick();
    req_addr_i[0] = 32'h28;
    bus_gnt_i     = 4'b0100;
    #3;
    chk("t4_gnt_b", 128'(req_gnt_o), 128'b0001);
    chk("t4_addr_b", 128'(bus_addr_o[2]), 128'h28);
    exp_push(2, 0);
    tick();
    req_addr_i[0] = 32'h48;
    bus_gnt_i     = 4'b0100;
    #3;
    chk("t4_full_req", 128'(bus_req_o), 128'b0);
    chk("t4_full_gnt", 128'(req_gnt_o), 128'b0);
    chk("t4_full_stall", 128'(stall_o), 128'b0001);
    tick();
    bus_gnt_i = 4'b0100;
    rsp(4'b0100, "t4_rsp_a");
    chk("t4_pop_req", 128'(bus_req_o), 128'b0);
    tick();
    bus_gnt_i = 4'b0100;
    #3;
    chk("t4_reassert", 128'(bus_req_o), 128'b0100);
    chk("t4_gnt_c", 128'(req_gnt_o), 128'b0001);
    exp_push(2, 0);
    tick();
    req_req_i = '0;
    rsp(4'b0100, "t4_rsp_b");
    tick();
    rsp(4'b0100, "t4_rsp_c");
    tick();
    #3;
    chk("t4_idle", 128'(busy_o), 128'(0));

    // req0 pending on port 0 may not move to port 1.
    tick();
    req_req_i     = 4'b0001;
    req_addr_i[0] = 32'h0;
    bus_gnt_i     = 4'b0001;
    #3;
    chk("t5_gnt_p0", 128'(req_gnt_o), 128'b0001);
    exp_push(0, 0);
    tick();
    req_addr_i[0] = 32'h4;
    bus_gnt_i     = 4'b0010;
    #3;
    chk("t5_block_req", 128'(bus_req_o), 128'b0);
    chk("t5_block_stall", 128'(stall_o), 128'b0001);
    tick();
    bus_gnt_i = 4'b0010;
    rsp(4'b0001, "t5_rsp_p0");
    chk("t5_still_block", 128'(bus_req_o), 128'b0);
    tick();
    bus_gnt_i = 4'b0010;
    #3;
    chk("t5_req_p1", 128'(bus_req_o), 128'b0010);
    chk("t5_gnt_p1", 128'(req_gnt_o), 128'b0001);
    exp_push(1, 0);
    tick();
    req_req_i = '0;
    rsp(4'b0010, "t5_rsp_p1");

    // Stray response sets sticky error; reset clears everything.
    tick();
    bus_rvalid_i   = 4'b0100;
    bus_rdata_i[2] = 32'hBAD0_BAD0;
    #3;
    chk("t6_no_rvalid", 128'(req_rvalid_o), 128'b0);
    chk("t6_rdata_zero", 128'(req_rdata_o), 128'(0));
    chk("t6_err_pre", 128'(err_o), 128'(0));
    tick();
    #3;
    chk("t6_err_set", 128'(err_o), 128'(1));
    tick();
    tick();
    #3;
    chk("t6_err_sticky", 128'(err_o), 128'(1));
    tick();
    req_req_i     = 4'b1001;
    req_addr_i[0] = 32'h0;
    req_addr_i[3] = 32'hC;
    bus_gnt_i     = 4'b1001;
    #3;
    chk("t6_burst_gnt", 128'(req_gnt_o), 128'b1001);
    tick();
    req_req_i = '0;
    rst_i     = 1'b1;
    #3;
    chk("t6_busy_pre", 128'(busy_o), 128'(1));
    tick();
    rst_i = 1'b0;
    #3;
    chk("t6_busy_rst", 128'(busy_o), 128'(0));
    chk("t6_err_rst", 128'(err_o), 128'(0));
    chk("t6_req_rst", 128'(bus_req_o), 128'(0));
    chk("sb_drain", 128'(sbq[0].size() + sbq[1].size() +
                         sbq[2].size() + sbq[3].size()), 128'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
